// File: rtl/debounce_scheduler_if.sv
// Key inputs and debounced outputs of debounce_scheduler, grouped as one bundle.
// The master side drives the raw keys; the slave side (the debouncer) drives the rest.
interface debounce_scheduler_if #(
  parameter int unsigned N = 4
) ();
  localparam int unsigned IDW = $clog2(N);

  logic [N-1:0]   in;
  logic [N-1:0]   out;
  logic [N-1:0]   rise;
  logic [N-1:0]   fall;
  logic           busy;
  logic [IDW-1:0] grant_id;

  modport master (
    output in,
    input  out,
    input  rise,
    input  fall,
    input  busy,
    input  grant_id
  );

  modport slave (
    input  in,
    output out,
    output rise,
    output fall,
    output busy,
    output grant_id
  );
endinterface

// File: rtl/debounce_scheduler.sv
// N-key debouncer sharing one 1 ms prescaler and one hold timer between all keys.
// Keys whose synchronized level disagrees with the debounced level are served round-robin.
module debounce_scheduler #(
  parameter bit          sim        = 1'b0,
  parameter int unsigned N          = 4,
  parameter int unsigned HOLD_TICKS = 10
) (
  input logic                clk,
  input logic                reset,
  debounce_scheduler_if.slave bus
);
  localparam int unsigned TICK_DIV = sim ? 32 : 100000;
  localparam int unsigned IDW      = $clog2(N);
  localparam int unsigned PW       = $clog2(TICK_DIV);
  localparam int unsigned MW       = $clog2(HOLD_TICKS + 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StTime = 1'b1;

  logic [N-1:0]   sync1_q, in_s_q;
  logic [N-1:0]   out_q, out_d;
  logic [N-1:0]   rise_q, rise_d;
  logic [N-1:0]   fall_q, fall_d;
  logic [0:0]     state_q, state_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [MW-1:0]  ms_cnt_q, ms_cnt_d;

  logic [N-1:0]   req;
  logic           tick;
  logic [IDW-1:0] pick;
  logic           pick_vld;

  assign req  = in_s_q ^ out_q;
  assign tick = (presc_q == PW'(TICK_DIV - 1));

  // Scan farthest-first so the last hit is the nearest requester after ptr.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned j = N; j >= 1; j--) begin
      if (req[IDW'((32'(ptr_q) + j) % N)]) begin
        pick     = IDW'((32'(ptr_q) + j) % N);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    presc_d    = presc_q;
    ms_cnt_d   = ms_cnt_q;
    out_d      = out_q;
    rise_d     = '0;
    fall_d     = '0;
    case (state_q)
      StIdle: begin
        if (pick_vld) begin
          grant_id_d = pick;
          presc_d    = '0;
          ms_cnt_d   = '0;
          state_d    = StTime;
        end
      end
      StTime: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          ms_cnt_d = ms_cnt_q + 1'b1;
        end
        // A bounce back to the committed level wins over a same-cycle commit.
        if (in_s_q[grant_id_q] == out_q[grant_id_q]) begin
          state_d = StIdle;
          ptr_d   = grant_id_q;
        end else if (tick && (ms_cnt_q == MW'(HOLD_TICKS - 1))) begin
          out_d[grant_id_q]  = in_s_q[grant_id_q];
          rise_d[grant_id_q] = in_s_q[grant_id_q];
          fall_d[grant_id_q] = ~in_s_q[grant_id_q];
          state_d            = StIdle;
          ptr_d              = grant_id_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      in_s_q     <= '0;
      out_q      <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      state_q    <= StIdle;
      grant_id_q <= '0;
      ptr_q      <= IDW'(N - 1);
      presc_q    <= '0;
      ms_cnt_q   <= '0;
    end else begin
      sync1_q    <= bus.in;
      in_s_q     <= sync1_q;
      out_q      <= out_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      presc_q    <= presc_d;
      ms_cnt_q   <= ms_cnt_d;
    end
  end

  assign bus.out      = out_q;
  assign bus.rise     = rise_q;
  assign bus.fall     = fall_q;
  assign bus.busy     = (state_q == StTime);
  assign bus.grant_id = grant_id_q;
endmodule

// File: tb/tb_debounce_scheduler.sv
// Bench for debounce_scheduler (sim timing, 4 keys, 10 ticks): deadline-based reference
// model checked every cycle, plus hand-computed checkpoints for each scenario.
module tb_debounce_scheduler;
  localparam int unsigned N    = 4;
  localparam int unsigned HOLD = 10;
  localparam int unsigned DIV  = 32;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   cyc;
  int   rise0_cnt;

  debounce_scheduler_if #(.N(N)) bus ();

  debounce_scheduler #(
    .sim        (1'b1),
    .N          (N),
    .HOLD_TICKS (HOLD)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  // Reference: a granted key commits a fixed HOLD*DIV cycles after its grant edge,
  // unless its synchronized level falls back to the debounced level first.
  logic [N-1:0] m_s1, m_s2, m_out, m_rise, m_fall;
  logic         m_busy;
  logic [1:0]   m_gid, m_ptr;
  int           deadline;

  function automatic logic [1:0] pick(input logic [N-1:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    for (int j = N; j >= 1; j--) begin
      idx = 2'((int'(ptr) + j) % N);
      if (req[idx]) pick = idx;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc      <= 0;
      m_s1     <= '0;
      m_s2     <= '0;
      m_out    <= '0;
      m_rise   <= '0;
      m_fall   <= '0;
      m_busy   <= 1'b0;
      m_gid    <= '0;
      m_ptr    <= 2'(N - 1);
      deadline <= 0;
    end else begin
      cyc    <= cyc + 1;
      m_s1   <= bus.in;
      m_s2   <= m_s1;
      m_rise <= '0;
      m_fall <= '0;
      if (!m_busy) begin
        if ((m_s2 ^ m_out) != '0) begin
          m_gid    <= pick(m_s2 ^ m_out, m_ptr);
          m_busy   <= 1'b1;
          deadline <= cyc + HOLD * DIV;
        end
      end else if (m_s2[m_gid] == m_out[m_gid]) begin
        m_busy <= 1'b0;
        m_ptr  <= m_gid;
      end else if (cyc == deadline) begin
        m_out[m_gid] <= m_s2[m_gid];
        if (m_s2[m_gid]) m_rise <= 4'b0001 << m_gid;
        else             m_fall <= 4'b0001 << m_gid;
        m_busy <= 1'b0;
        m_ptr  <= m_gid;
      end
    end
  end

  always @(negedge clk) begin
    chk("out",      32'(bus.out),      32'(m_out));
    chk("rise",     32'(bus.rise),     32'(m_rise));
    chk("fall",     32'(bus.fall),     32'(m_fall));
    chk("busy",     32'(bus.busy),     32'(m_busy));
    chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
    chk("pulse_onehot", 32'($countones(bus.rise | bus.fall) <= 1), 32'd1);
    if (bus.rise[0]) rise0_cnt++;
  end

  task automatic wait_cyc(input int tgt);
    while (cyc < tgt) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    int k;
    int r0;
    tests     = 0;
    fails     = 0;
    rise0_cnt = 0;
    rst_n     = 1'b0;
    bus.in    = '0;
    repeat (3) @(negedge clk);
    chk("rst_out",   32'(bus.out),      32'd0);
    chk("rst_busy",  32'(bus.busy),     32'd0);
    chk("rst_grant", 32'(bus.grant_id), 32'd0);
    rst_n = 1'b1;

    // Quiet inputs: nothing happens.
    wait_cyc(1000);
    chk("idle_out",  32'(bus.out),  32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Clean rise on key 1.
    bus.in = 4'b0010; k = cyc + 1;
    wait_cyc(k + 1);   chk("k1_nobusy", 32'(bus.busy), 32'd0);
    wait_cyc(k + 2);   chk("k1_busy", 32'(bus.busy), 32'd1);
                       chk("k1_gid", 32'(bus.grant_id), 32'd1);
    wait_cyc(k + 321); chk("k1_early", 32'(bus.out), 32'b0000);
    wait_cyc(k + 322); chk("k1_out", 32'(bus.out), 32'b0010);
                       chk("k1_rise", 32'(bus.rise), 32'b0010);
                       chk("k1_busy_drop", 32'(bus.busy), 32'd0);
    wait_cyc(k + 323); chk("k1_rise_end", 32'(bus.rise), 32'd0);

    // Bouncing key 0, then a stable high.
    r0 = rise0_cnt;
    for (int i = 0; i < 8; i++) begin
      bus.in[0] = ~bus.in[0];
      wait_cyc(cyc + 50);
    end
    chk("bnc_out", 32'(bus.out), 32'b0010);
    bus.in[0] = 1'b1; k = cyc + 1;
    wait_cyc(k + 321); chk("bnc_early", 32'(bus.out), 32'b0010);
    wait_cyc(k + 322); chk("bnc_out1", 32'(bus.out), 32'b0011);
                       chk("bnc_rise", 32'(bus.rise), 32'b0001);
    wait_cyc(k + 330); chk("bnc_rise_cnt", 32'(rise0_cnt - r0), 32'd1);

    // ptr=0: keys 3 and 0 change together, key 3 is served first.
    bus.in = 4'b1010; k = cyc + 1;
    wait_cyc(k + 2);   chk("rr_gid3", 32'(bus.grant_id), 32'd3);
    wait_cyc(k + 322); chk("rr_out3", 32'(bus.out), 32'b1011);
                       chk("rr_rise3", 32'(bus.rise), 32'b1000);
    wait_cyc(k + 323); chk("rr_gid0", 32'(bus.grant_id), 32'd0);
                       chk("rr_busy0", 32'(bus.busy), 32'd1);
    wait_cyc(k + 643); chk("rr_out0", 32'(bus.out), 32'b1010);
                       chk("rr_fall0", 32'(bus.fall), 32'b0001);

    // Key 3 falls after having debounced high.
    bus.in = 4'b0010; k = cyc + 1;
    wait_cyc(k + 322); chk("f3_out", 32'(bus.out), 32'b0010);
                       chk("f3_fall", 32'(bus.fall), 32'b1000);
    wait_cyc(k + 323); chk("f3_fall_end", 32'(bus.fall), 32'd0);

    // ptr=3: keys 0 and 2 rise together, key 0 first.
    bus.in = 4'b0111; k = cyc + 1;
    wait_cyc(k + 322); chk("two_out0", 32'(bus.out), 32'b0011);
                       chk("two_rise0", 32'(bus.rise), 32'b0001);
    wait_cyc(k + 323); chk("two_gid2", 32'(bus.grant_id), 32'd2);
                       chk("two_busy2", 32'(bus.busy), 32'd1);
    wait_cyc(k + 642); chk("two_early2", 32'(bus.out), 32'b0011);
    wait_cyc(k + 643); chk("two_out2", 32'(bus.out), 32'b0111);
                       chk("two_rise2", 32'(bus.rise), 32'b0100);

    // Reset asserted in the middle of a timing window.
    bus.in = 4'b1111; k = cyc + 1;
    wait_cyc(k + 100); chk("mid_busy", 32'(bus.busy), 32'd1);
                       chk("mid_gid", 32'(bus.grant_id), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out",  32'(bus.out),  32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_gid",  32'(bus.grant_id), 32'd0);
    chk("mid_rst_pulse", 32'(bus.rise | bus.fall), 32'd0);
    bus.in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(cyc + 50);
    chk("post_out",  32'(bus.out),  32'd0);
    chk("post_busy", 32'(bus.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
